// File: rtl/nv_nvdla_cdp_rdma_csb_bridge_pkg.sv
// CDP RDMA CSB bridge: request/response field layout, default decode constants,
// register-group select encoding and the address decode helpers.
package nv_nvdla_cdp_rdma_csb_bridge_pkg;

    localparam int REQ_PD_W        = 63;
    localparam int REQ_ADDR_LSB    = 0;
    localparam int REQ_ADDR_W      = 22;
    localparam int REQ_WDAT_LSB    = 22;
    localparam int REQ_WDAT_W      = 32;
    localparam int REQ_WRITE_BIT   = 54;
    localparam int REQ_NPOSTED_BIT = 55;

    localparam int RESP_PD_W         = 34;
    localparam int RESP_RDATA_LSB    = 0;
    localparam int RESP_RDATA_W      = 32;
    localparam int RESP_ERROR_BIT    = 32;
    localparam int RESP_IS_WRITE_BIT = 33;

    localparam logic [11:0] BASE_ADDR_DFLT  = 12'h00E;
    localparam logic [11:0] DUAL_START_DFLT = 12'h008;

    typedef enum logic [1:0] {
        GRP_SINGLE = 2'd0,
        GRP_DUAL0  = 2'd1,
        GRP_DUAL1  = 2'd2
    } grp_sel_e;

    function automatic logic addr_hit(input logic [REQ_ADDR_W-1:0] addr,
                                      input logic [11:0]           base);
        return (addr[21:10] == base);
    endfunction

    // Offsets below dual_start live in the single group; the rest follow producer.
    function automatic grp_sel_e addr_decode(input logic [11:0] offset,
                                             input logic [11:0] dual_start,
                                             input logic        producer);
        if (offset < dual_start) begin
            return GRP_SINGLE;
        end
        return producer ? GRP_DUAL1 : GRP_DUAL0;
    endfunction

endpackage

// File: rtl/nv_nvdla_cdp_rdma_csb_bridge.sv
// CSB-to-register bridge for CDP RDMA: write strobes 1 cycle and responses 2 cycles
// after acceptance; fully pipelined, req_prdy is held high whenever out of reset.
module nv_nvdla_cdp_rdma_csb_bridge
    import nv_nvdla_cdp_rdma_csb_bridge_pkg::*;
#(
    parameter logic [11:0] BASE_ADDR  = BASE_ADDR_DFLT,
    parameter logic [11:0] DUAL_START = DUAL_START_DFLT
) (
    input  logic                 nvdla_core_clk,
    input  logic                 nvdla_core_rstn,
    input  logic                 csb2cdp_rdma_req_pvld,
    output logic                 csb2cdp_rdma_req_prdy,
    input  logic [REQ_PD_W-1:0]  csb2cdp_rdma_req_pd,
    output logic                 cdp_rdma2csb_resp_valid,
    output logic [RESP_PD_W-1:0] cdp_rdma2csb_resp_pd,
    output logic [11:0]          reg_offset,
    output logic [31:0]          reg_wr_data,
    output logic                 s_reg_wr_en,
    output logic                 d0_reg_wr_en,
    output logic                 d1_reg_wr_en,
    input  logic [31:0]          s_reg_rd_data,
    input  logic [31:0]          d0_reg_rd_data,
    input  logic [31:0]          d1_reg_rd_data,
    input  logic                 producer
);

    logic                  req_acc;
    logic                  s1_vld;
    logic [REQ_ADDR_W-1:0] s1_addr;
    logic [REQ_WDAT_W-1:0] s1_wdat;
    logic                  s1_write;
    logic                  s1_nposted;
    logic                  s1_hit;
    grp_sel_e              s1_grp;
    logic                  wr_fire;
    logic                  resp_fire;
    logic [31:0]           rd_mux;
    logic [RESP_PD_W-1:0]  resp_nxt;
    logic                  unused_req_pd;

    assign csb2cdp_rdma_req_prdy = nvdla_core_rstn;
    assign req_acc               = csb2cdp_rdma_req_pvld & csb2cdp_rdma_req_prdy;
    assign unused_req_pd         = ^csb2cdp_rdma_req_pd[REQ_PD_W-1:REQ_NPOSTED_BIT+1];

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            s1_vld     <= 1'b0;
            s1_addr    <= '0;
            s1_wdat    <= '0;
            s1_write   <= 1'b0;
            s1_nposted <= 1'b0;
        end else begin
            s1_vld <= req_acc;
            if (req_acc) begin
                s1_addr    <= csb2cdp_rdma_req_pd[REQ_ADDR_LSB +: REQ_ADDR_W];
                s1_wdat    <= csb2cdp_rdma_req_pd[REQ_WDAT_LSB +: REQ_WDAT_W];
                s1_write   <= csb2cdp_rdma_req_pd[REQ_WRITE_BIT];
                s1_nposted <= csb2cdp_rdma_req_pd[REQ_NPOSTED_BIT];
            end
        end
    end

    assign reg_offset  = {s1_addr[9:0], 2'b00};
    assign reg_wr_data = s1_wdat;

    // producer is looked at only in stage 1, so a write that flips it steers later requests.
    assign s1_hit = addr_hit(s1_addr, BASE_ADDR);
    assign s1_grp = addr_decode(reg_offset, DUAL_START, producer);

    assign wr_fire      = s1_vld & s1_write & s1_hit;
    assign s_reg_wr_en  = wr_fire & (s1_grp == GRP_SINGLE);
    assign d0_reg_wr_en = wr_fire & (s1_grp == GRP_DUAL0);
    assign d1_reg_wr_en = wr_fire & (s1_grp == GRP_DUAL1);

    always_comb begin
        rd_mux = '0;
        case (s1_grp)
            GRP_SINGLE: rd_mux = s_reg_rd_data;
            GRP_DUAL0:  rd_mux = d0_reg_rd_data;
            GRP_DUAL1:  rd_mux = d1_reg_rd_data;
            default:    rd_mux = '0;
        endcase
    end

    assign resp_fire = s1_vld & (~s1_write | s1_nposted);

    always_comb begin
        resp_nxt                                    = '0;
        resp_nxt[RESP_IS_WRITE_BIT]                 = s1_write;
        resp_nxt[RESP_ERROR_BIT]                    = ~s1_hit;
        resp_nxt[RESP_RDATA_LSB +: RESP_RDATA_W]    = (s1_write | ~s1_hit) ? 32'h0 : rd_mux;
    end

    // resp_pd only loads on a response so it keeps the last value between responses.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            cdp_rdma2csb_resp_valid <= 1'b0;
            cdp_rdma2csb_resp_pd    <= '0;
        end else begin
            cdp_rdma2csb_resp_valid <= resp_fire;
            if (resp_fire) begin
                cdp_rdma2csb_resp_pd <= resp_nxt;
            end
        end
    end

endmodule

// File: doc/nv_nvdla_cdp_rdma_csb_bridge.md
NV_NVDLA_CDP_RDMA_CSB_BRIDGE -- requirements
Module: nv_nvdla_cdp_rdma_csb_bridge

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 12'h00E, meaning the required value of req word-address bits [21:10].
REQ-002 SHALL have parameter DUAL_START, default 12'h008, meaning the lowest byte offset that is routed to the dual register groups.
REQ-003 SHALL have port nvdla_core_clk  input  1  core clock.
REQ-004 SHALL have port nvdla_core_rstn  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port csb2cdp_rdma_req_pvld  input  1  request valid.
REQ-006 SHALL have port csb2cdp_rdma_req_prdy  output  1  request ready.
REQ-007 SHALL have port csb2cdp_rdma_req_pd  input  63  request fields: addr[21:0], wdat[53:22], write[54], nposted[55]; bits [62:56] are ignored.
REQ-008 SHALL have port cdp_rdma2csb_resp_valid  output  1  response valid, single-cycle pulse.
REQ-009 SHALL have port cdp_rdma2csb_resp_pd  output  34  response fields: is_write[33], error[32], rdata[31:0].
REQ-010 SHALL have port reg_offset  output  12  byte offset, shared by all register groups.
REQ-011 SHALL have port reg_wr_data  output  32  write data, shared by all register groups.
REQ-012 SHALL have ports s_reg_wr_en, d0_reg_wr_en, d1_reg_wr_en  output  1 each  write strobes for the single, dual-0 and dual-1 groups.
REQ-013 SHALL have ports s_reg_rd_data, d0_reg_rd_data, d1_reg_rd_data  input  32 each  combinational read data from each group.
REQ-014 SHALL have port producer  input  1  dual-group select, driven from the single group.

Function
REQ-015 csb2cdp_rdma_req_prdy SHALL be held at 1 whenever the block is out of reset, so one request can be accepted every cycle.
REQ-016 An accepted request SHALL be registered into stage-1 flops; the fields latched are addr, wdat, write, nposted, and a valid bit.
REQ-017 reg_offset SHALL equal {stage-1 addr[9:0], 2'b00}, and reg_wr_data SHALL equal the stage-1 wdat.
REQ-018 A request SHALL be a hit when its addr[21:10] equals BASE_ADDR; otherwise it is a miss.
REQ-019 Write strobes SHALL be asserted in the cycle after acceptance, one cycle wide, only for stage-1 write hits, as follows:
- offset < DUAL_START: s_reg_wr_en;
- else producer=0: d0_reg_wr_en;
- else producer=1: d1_reg_wr_en.
REQ-020 At most one write strobe SHALL be high in any cycle.
REQ-021 The group for a read SHALL be selected with the same rule as REQ-019, and its read data SHALL be captured at the end of stage 1.
REQ-022 A read response SHALL be issued 2 cycles after acceptance, with is_write=0, error=0 and rdata set to the captured data.
REQ-023 A non-posted write SHALL return a response 2 cycles after acceptance, with is_write=1, error=0 and rdata=0.
REQ-024 A posted write SHALL produce no response.
REQ-025 A read miss SHALL respond with error=1 and rdata=0.
REQ-026 A non-posted write miss SHALL respond with error=1; a posted write miss SHALL produce no response.
REQ-027 A write miss SHALL never assert any write strobe.
REQ-028 Back-to-back requests SHALL be handled in a fully pipelined way, with no loss or reordering of responses.
REQ-029 producer SHALL be sampled in stage 1, so that a write that toggles producer affects only later requests, not itself.
REQ-030 When no response is issued, resp_pd SHALL hold its last value.

Reset
REQ-031 While reset is asserted:
- resp_valid, resp_pd, all write strobes, the stage-1 valid bit, reg_offset and reg_wr_data SHALL be 0;
- req_prdy SHALL be 0.
REQ-032 A reset asserted mid-operation SHALL drop any in-flight request with no response and no write strobe.
REQ-033 The first request SHALL be accepted in the first cycle after reset is released.

Structure
REQ-034 A shared package SHALL hold the req_pd and resp_pd field positions and widths, the BASE_ADDR and DUAL_START defaults, and the group-select encoding.
REQ-035 The block SHALL be a single module with no sub-modules; address decode SHALL be a package function.

Verification
REQ-036 Scenario: with producer=0, a non-posted write to addr 0x3802 with wdat 0xA5A5_0001.
- Required: d0_reg_wr_en high 1 cycle later, with reg_offset 0x008.
- Required: a response 2 cycles after acceptance with resp_pd = {1,0,0}.
REQ-037 Scenario: a read from addr 0x3800 with s_reg_rd_data=0x0001_0003.
- Required: resp_pd 0x0_0001_0003, 2 cycles after acceptance.
REQ-038 Scenario: a posted write of 1 to offset 0x004, then a write to 0x3802 on the next cycle.
- Required: s_reg_wr_en high, then d1_reg_wr_en high.
- Required: no response for the posted write.
REQ-039 Scenario: a read from addr 0x0000 (miss).
- Required: error=1 and rdata 0.
- Required: no write strobe during the access.
REQ-040 Scenario: 8 consecutive reads, one per cycle.
- Required: 8 in-order responses in consecutive cycles.
- Then: reset asserted with one request in stage 1 yields no response.
